// File: rtl/instr_encoder.sv
// Instruction encoder and loader: packs abstract instruction requests into
// 32-bit MIPS words, queues them in a small FIFO and streams them into
// instruction memory at sequential word addresses.
module instr_encoder #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] BASE_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [25:0]       req_imm,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err_illegal,
  output logic              wrapped,
  output logic [ADDR_W:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]     FULL_OCC = (PW+1)'(DEPTH);
  localparam logic [PW:0]     OCC_ONE  = 1;
  localparam logic [PW-1:0]   PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0] CNT_ONE  = 1;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t          state, state_nx;
  logic [31:0]     fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     occ;
  logic            empty, full;
  logic            accept, illegal, push, pop, drop_all;
  logic            flush_pend;
  logic [31:0]     enc_word;

  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [25:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
      4'd5:    w = {6'b100011, rs, rt, imm[15:0]};
      4'd6:    w = {6'b101011, rs, rt, imm[15:0]};
      4'd7:    w = {6'b000100, rs, rt, imm[15:0]};
      4'd8:    w = {6'b001000, rs, rt, imm[15:0]};
      4'd9:    w = {6'b001100, rs, rt, imm[15:0]};
      4'd10:   w = {6'b001101, rs, rt, imm[15:0]};
      4'd11:   w = {6'b001110, rs, rt, imm[15:0]};
      4'd12:   w = {6'b001010, rs, rt, imm[15:0]};
      4'd13:   w = {6'b000010, imm};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign enc_word  = encode(req_op, req_rs, req_rt, req_rd, req_imm);
  assign empty     = (occ == '0);
  assign full      = (occ == FULL_OCC);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign illegal   = accept && (req_op == 4'd15);
  // A request arriving together with flush is thrown away with the queue.
  assign push      = accept && !illegal && !flush;
  assign pop       = (state == S_WRITE) && mem_ack;
  // Queue is emptied by flush in IDLE, or after the in-flight write lands.
  assign drop_all  = ((state == S_IDLE) && flush) || (pop && (flush || flush_pend));
  assign mem_we    = (state == S_WRITE);

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (drop_all) begin
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state: stay in WRITE only while more words remain after this ack.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!empty && !flush) state_nx = S_WRITE;
      S_WRITE: if (mem_ack) begin
                 if (flush || flush_pend || (occ <= OCC_ONE)) state_nx = S_IDLE;
                 else                                          state_nx = S_WRITE;
               end
      default: state_nx = S_IDLE;
    endcase
  end

  // Write-port registers: address, data, progress counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= BASE_RST;
      mem_wdata   <= '0;
      count       <= '0;
      wrapped     <= 1'b0;
      err_illegal <= 1'b0;
      flush_pend  <= 1'b0;
    end else begin
      err_illegal <= illegal;
      if (pop)                              flush_pend <= 1'b0;
      else if ((state == S_WRITE) && flush) flush_pend <= 1'b1;
      if ((state == S_IDLE) && (state_nx == S_WRITE))
        mem_wdata <= fifo_mem[rd_ptr];
      else if (pop && (state_nx == S_WRITE))
        mem_wdata <= fifo_mem[rd_ptr + PTR_ONE];
      if ((state == S_IDLE) && load_base) begin
        mem_addr <= base_addr;
        count    <= '0;
        wrapped  <= 1'b0;
      end else if (pop) begin
        mem_addr <= mem_addr + ADDR_ONE;
        count    <= count + CNT_ONE;
        if (mem_addr == '1) wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: hand-computed encodings, stall,
// wrap, illegal-op, flush and asynchronous-reset scenarios.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [25:0] req_imm;
  logic        load_base;
  logic [7:0]  base_addr;
  logic        flush;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        err_illegal;
  logic        wrapped;
  logic [8:0]  count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  waddr[$];
  logic [31:0] wdata[$];
  time         wtime[$];

  instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_RST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .load_base(load_base), .base_addr(base_addr),
    .flush(flush), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .err_illegal(err_illegal), .wrapped(wrapped), .count(count)
  );

  always #5 clk = ~clk;

  // Record every completed memory write (strobe and ack together).
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ack) begin
      waddr.push_back(mem_addr);
      wdata.push_back(mem_wdata);
      wtime.push_back($time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [25:0] imm);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
    req_valid = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 0; req_op = 0; req_rs = 0; req_rt = 0; req_rd = 0; req_imm = 0;
    load_base = 0; base_addr = 0; flush = 0; mem_ack = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    waddr.delete(); wdata.delete(); wtime.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got=%h exp=00", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_illegal); end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL rst_wrapped got=%b exp=0", wrapped); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
  endtask

  task automatic test_single();
    do_reset();
    mem_ack = 1'b1;
    put(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_early got=%b exp=0", mem_we); end
    cyc();
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL single_addr got=%h exp=00", mem_addr); end
    checks++; if (mem_wdata !== 32'h00221820) begin errors++; $display("FAIL single_wdata got=%h exp=00221820", mem_wdata); end
    cyc();
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_done got=%b exp=0", mem_we); end
    checks++; if (count !== 9'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [4];
    exp_w = '{32'h8C850008, 32'h1022FFFF, 32'h20080005, 32'h08000010};
    do_reset();
    mem_ack = 1'b1;
    put(4'd5, 5'd4, 5'd5, 5'd0, 26'h0008);
    put(4'd7, 5'd1, 5'd2, 5'd0, 26'h00FFFF);
    put(4'd8, 5'd0, 5'd8, 5'd0, 26'h0005);
    put(4'd13, 5'd0, 5'd0, 5'd0, 26'h10);
    req_valid = 1'b0;
    repeat (8) cyc();
    checks++; if (wdata.size() != 4) begin errors++; $display("FAIL stream_n got=%0d exp=4", wdata.size()); end
    for (int i = 0; i < 4 && i < wdata.size(); i++) begin
      checks++; if (waddr[i] !== 8'(i)) begin errors++; $display("FAIL stream_addr%0d got=%h exp=%h", i, waddr[i], 8'(i)); end
      checks++; if (wdata[i] !== exp_w[i]) begin errors++; $display("FAIL stream_data%0d got=%h exp=%h", i, wdata[i], exp_w[i]); end
      if (i > 0) begin
        checks++; if (wtime[i] - wtime[i-1] != 10) begin errors++; $display("FAIL stream_b2b%0d gap=%0t exp=10", i, wtime[i] - wtime[i-1]); end
      end
    end
  endtask

  task automatic test_itype();
    logic [31:0] exp_w [4];
    exp_w = '{32'hAFBF1234, 32'h3401ABCD, 32'h38640001, 32'h28A60007};
    do_reset();
    mem_ack = 1'b1;
    put(4'd6, 5'd29, 5'd31, 5'd7, 26'h0001234);
    put(4'd10, 5'd0, 5'd1, 5'd0, 26'h3FFABCD);
    put(4'd11, 5'd3, 5'd4, 5'd0, 26'h0001);
    put(4'd12, 5'd5, 5'd6, 5'd0, 26'h0007);
    req_valid = 1'b0;
    repeat (8) cyc();
    checks++; if (wdata.size() != 4) begin errors++; $display("FAIL itype_n got=%0d exp=4", wdata.size()); end
    for (int i = 0; i < 4 && i < wdata.size(); i++) begin
      checks++; if (wdata[i] !== exp_w[i]) begin errors++; $display("FAIL itype_data%0d got=%h exp=%h", i, wdata[i], exp_w[i]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_w [5];
    logic        stable;
    exp_w = '{32'h00221822, 32'h00853024, 32'h00E84825, 32'h0021082A, 32'h304300FF};
    do_reset();
    mem_ack = 1'b0;
    put(4'd1, 5'd1, 5'd2, 5'd3, 26'd0);
    put(4'd2, 5'd4, 5'd5, 5'd6, 26'd0);
    put(4'd3, 5'd7, 5'd8, 5'd9, 26'd0);
    put(4'd4, 5'd1, 5'd1, 5'd1, 26'd0);
    req_op = 4'd9; req_rs = 5'd2; req_rt = 5'd3; req_rd = 5'd0; req_imm = 26'h00FF;
    req_valid = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", req_ready); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL stall_we got=%b exp=1", mem_we); end
    checks++; if (mem_wdata !== exp_w[0]) begin errors++; $display("FAIL stall_head got=%h exp=%h", mem_wdata, exp_w[0]); end
    stable = 1'b1;
    repeat (7) begin
      cyc();
      @(negedge clk);
      if (req_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== exp_w[0]) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable got=%b exp=1 (addr=%h data=%h)", stable, mem_addr, mem_wdata); end
    cyc();
    mem_ack = 1'b1;
    cyc();
    cyc();
    req_valid = 1'b0;
    repeat (10) cyc();
    checks++; if (wdata.size() != 5) begin errors++; $display("FAIL stall_n got=%0d exp=5", wdata.size()); end
    for (int i = 0; i < 5 && i < wdata.size(); i++) begin
      checks++; if (waddr[i] !== 8'(i) || wdata[i] !== exp_w[i]) begin
        errors++; $display("FAIL stall_word%0d got=%h@%h exp=%h@%h", i, wdata[i], waddr[i], exp_w[i], 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_ack = 1'b1;
    load_base = 1'b1; base_addr = 8'hFE;
    cyc();
    load_base = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_load got=%h exp=fe", mem_addr); end
    put(4'd14, 5'd0, 5'd0, 5'd0, 26'd0);
    put(4'd14, 5'd0, 5'd0, 5'd0, 26'd0);
    put(4'd14, 5'd0, 5'd0, 5'd0, 26'd0);
    req_valid = 1'b0;
    repeat (6) cyc();
    checks++; if (wdata.size() != 3) begin errors++; $display("FAIL wrap_n got=%0d exp=3", wdata.size()); end
    if (wdata.size() == 3) begin
      checks++; if (waddr[0] !== 8'hFE || waddr[1] !== 8'hFF || waddr[2] !== 8'h00) begin
        errors++; $display("FAIL wrap_addrs got=%h,%h,%h exp=fe,ff,00", waddr[0], waddr[1], waddr[2]);
      end
      checks++; if (wdata[2] !== 32'h0) begin errors++; $display("FAIL wrap_nop got=%h exp=0", wdata[2]); end
    end
    @(negedge clk);
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_flag got=%b exp=1", wrapped); end
    checks++; if (count !== 9'd3) begin errors++; $display("FAIL wrap_count got=%0d exp=3", count); end
    cyc();
    load_base = 1'b1; base_addr = 8'h10;
    cyc();
    load_base = 1'b0;
    @(negedge clk);
    checks++; if (wrapped !== 1'b0 || count !== 9'd0 || mem_addr !== 8'h10) begin
      errors++; $display("FAIL wrap_reload got=%b/%0d/%h exp=0/0/10", wrapped, count, mem_addr);
    end
  endtask

  task automatic test_illegal();
    logic we_seen;
    do_reset();
    mem_ack = 1'b1;
    put(4'd15, 5'd1, 5'd2, 5'd3, 26'd0);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse got=%b exp=1", err_illegal); end
    we_seen = mem_we;
    cyc();
    @(negedge clk);
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_once got=%b exp=0", err_illegal); end
    repeat (4) begin
      if (mem_we) we_seen = 1'b1;
      cyc();
      @(negedge clk);
    end
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL illegal_we got=%b exp=0", we_seen); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL illegal_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    do_reset();
    mem_ack = 1'b0;
    put(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    put(4'd1, 5'd1, 5'd2, 5'd3, 26'd0);
    put(4'd2, 5'd4, 5'd5, 5'd6, 26'd0);
    req_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL flush_hold got=%b exp=1", mem_we); end
    cyc();
    mem_ack = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    checks++; if (wdata.size() != 1) begin errors++; $display("FAIL flush_n got=%0d exp=1", wdata.size()); end
    if (wdata.size() > 0) begin
      checks++; if (wdata[0] !== 32'h00221820) begin errors++; $display("FAIL flush_word got=%h exp=00221820", wdata[0]); end
    end
    checks++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle got=we%b/rdy%b exp=we0/rdy1", mem_we, req_ready);
    end
    checks++; if (count !== 9'd1) begin errors++; $display("FAIL flush_count got=%0d exp=1", count); end
    // Request coinciding with flush in IDLE must be discarded.
    req_op = 4'd0; req_valid = 1'b1; flush = 1'b1;
    cyc();
    req_valid = 1'b0; flush = 1'b0;
    repeat (5) cyc();
    checks++; if (wdata.size() != 1 || count !== 9'd1) begin
      errors++; $display("FAIL flush_sameq got=%0d/%0d exp=1/1", wdata.size(), count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_ack = 1'b0;
    put(4'd3, 5'd1, 5'd2, 5'd3, 26'd0);
    req_valid = 1'b0;
    cyc();
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b exp=1", mem_we); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL arst_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0 || count !== 9'd0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL arst_state got=%h/%h/%0d/%b exp=00/0/0/1", mem_addr, mem_wdata, count, req_ready);
    end
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL arst_empty got=%b exp=0", mem_we); end
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 0; req_op = 0; req_rs = 0; req_rt = 0; req_rd = 0; req_imm = 0;
    load_base = 0; base_addr = 0; flush = 0; mem_ack = 0;
    test_reset();
    test_single();
    test_stream();
    test_itype();
    test_stall();
    test_wrap();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
